vga_fb_dbuf: RTL

//  Parametrised successor framebuffer for the VGA pipeline. Holds BPP-bit colour indices
//  in one or two row-major pixel buffers and maps indices to RGB through a programmable palette.

---
 rtl/vga_fb_dbuf.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/vga_fb_dbuf.sv
// Double-buffered indexed-colour framebuffer with palette lookup, background clear engine
// and tear-free front/back swap at frame end.
module vga_fb_dbuf #(
  parameter int unsigned H_MAX      = 1280,
  parameter int unsigned V_MAX      = 1024,
  parameter int unsigned H_W        = 11,
  parameter int unsigned V_W        = 11,
  parameter int unsigned BPP        = 2,
  parameter int unsigned RGB_W      = 12,
  parameter int unsigned DOUBLE_BUF = 1
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             pixel_enable_i,
  input  logic [H_W-1:0]   hcount_i,
  input  logic [V_W-1:0]   vcount_i,
  input  logic             frame_end_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [H_W-1:0]   wr_x_i,
  input  logic [V_W-1:0]   wr_y_i,
  input  logic [BPP-1:0]   wr_idx_i,
  output logic             wr_oob_o,
  input  logic             clear_req_i,
  output logic             clear_busy_o,
  input  logic             pal_we_i,
  input  logic [BPP-1:0]   pal_idx_i,
  input  logic [RGB_W-1:0] pal_rgb_i,
  input  logic             swap_req_i,
  output logic             swap_pending_o,
  output logic             front_sel_o,
  output logic [RGB_W-1:0] rgb_o,
  output logic             rgb_valid_o
);

  localparam int unsigned Depth    = H_MAX * V_MAX;
  localparam int unsigned NumBuf   = (DOUBLE_BUF != 0) ? 2 : 1;
  localparam int unsigned MemDepth = NumBuf * Depth;
  localparam int unsigned MemAw    = (MemDepth > 1) ? $clog2(MemDepth) : 1;
  localparam int unsigned CntW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned PalDepth = 2 ** BPP;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  function automatic logic [RGB_W-1:0] pal_default(int unsigned i);
    case (i)
      1:       return RGB_W'(12'hFFF);
      2:       return RGB_W'(12'hF00);
      3:       return RGB_W'(12'h0F0);
      default: return '0;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [CntW-1:0]   clr_cnt_q, clr_cnt_d;
  logic              front_q, front_d;
  logic              pend_q, pend_d;
  logic              oob_q;
  logic              en_q;
  logic [BPP-1:0]    idx_q;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic              rgb_valid_q;
  logic [RGB_W-1:0]  pal_q [PalDepth];
  logic [BPP-1:0]    mem [MemDepth];

  logic              wr_accept, wr_in_range, rd_in_range;
  logic              pix_we, clr_we, back_sel;
  logic              swap_want, do_swap;
  logic [31:0]       wr_lin, rd_lin;
  logic [MemAw-1:0]  wr_addr, clr_addr, rd_addr;

  // Range checks are done before linearising so wrapped addresses never reach the memory.
  always_comb begin
    wr_in_range = (32'(wr_x_i) < H_MAX) && (32'(wr_y_i) < V_MAX);
    rd_in_range = (32'(hcount_i) < H_MAX) && (32'(vcount_i) < V_MAX);
    wr_accept   = wr_valid_i && (state_q == StIdle);
    back_sel    = (NumBuf == 2) ? ~front_q : 1'b0;
    wr_lin      = 32'(wr_y_i) * H_MAX + 32'(wr_x_i);
    rd_lin      = 32'(vcount_i) * H_MAX + 32'(hcount_i);
    wr_addr     = MemAw'(32'(back_sel) * Depth + wr_lin);
    clr_addr    = MemAw'(32'(back_sel) * Depth + 32'(clr_cnt_q));
    rd_addr     = MemAw'(32'((NumBuf == 2) ? front_q : 1'b0) * Depth + rd_lin);
    pix_we      = arstn_i && wr_accept && wr_in_range;
    clr_we      = arstn_i && (state_q == StClear);
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StIdle: begin
        clr_cnt_d = '0;
        if (clear_req_i) state_d = StClear;
      end
      StClear: begin
        if (clr_cnt_q == CntW'(Depth - 1)) begin
          state_d = StIdle;
        end else begin
          clr_cnt_d = clr_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A request arriving with frame_end swaps immediately; otherwise it stays latched.
  always_comb begin
    swap_want = pend_q | swap_req_i;
    do_swap   = swap_want && frame_end_i && (state_q == StIdle);
    pend_d    = (NumBuf == 2) ? (swap_want & ~do_swap) : 1'b0;
    front_d   = (NumBuf == 2) ? (front_q ^ do_swap) : 1'b0;
    rgb_d     = en_q ? pal_q[idx_q] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q     <= StIdle;
      clr_cnt_q   <= '0;
      front_q     <= 1'b0;
      pend_q      <= 1'b0;
      oob_q       <= 1'b0;
      en_q        <= 1'b0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      front_q     <= front_d;
      pend_q      <= pend_d;
      oob_q       <= wr_accept && !wr_in_range;
      en_q        <= pixel_enable_i;
      rgb_q       <= rgb_d;
      rgb_valid_q <= en_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      for (int unsigned i = 0; i < PalDepth; i++) begin
        pal_q[i] <= pal_default(i);
      end
    end else if (pal_we_i) begin
      pal_q[pal_idx_i] <= pal_rgb_i;
    end
  end

  // Pixel storage is intentionally not reset; read-before-write on a shared address.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (pix_we) begin
      mem[wr_addr] <= wr_idx_i;
    end
    idx_q <= rd_in_range ? mem[rd_addr] : '0;
  end

  assign wr_ready_o     = (state_q == StIdle);
  assign clear_busy_o   = (state_q == StClear);
  assign wr_oob_o       = oob_q;
  assign swap_pending_o = pend_q;
  assign front_sel_o    = front_q;
  assign rgb_o          = rgb_q;
  assign rgb_valid_o    = rgb_valid_q;

endmodule
